// File: rtl/spi_frame_tx_buffer_if.sv
// Write-side, commit and tx-side signals of the SPI return-path frame buffer.
// The buffer itself connects through the slave modport; its user connects through master.
interface spi_frame_tx_buffer_if #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 256
);
  localparam int LEN_W = $clog2(DEPTH + 1);

  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              commit;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [LEN_W-1:0]  frame_len;
  logic              busy;
  logic              err_rsvd;
  logic              err_ovf;

  modport slave (
    input  wr_valid, wr_data, commit, tx_ready,
    output wr_ready, tx_data, tx_valid, frame_len, busy, err_rsvd, err_ovf
  );

  modport master (
    output wr_valid, wr_data, commit, tx_ready,
    input  wr_ready, tx_data, tx_valid, frame_len, busy, err_rsvd, err_ovf
  );
endinterface

// File: rtl/spi_frame_tx_buffer.sv
// Return-path frame buffer toward the STM32: collects status/position words, then on
// commit replays them to the SPI slave shifter followed by the end-of-frame code.
module spi_frame_tx_buffer #(
  parameter int          DATA_W    = 9,
  parameter int          DEPTH     = 256,
  parameter int unsigned TERM_CODE = 256,
  parameter int unsigned IDLE_CODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_frame_tx_buffer_if.slave bus
);
  localparam int                PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                LEN_W   = $clog2(DEPTH + 1);
  localparam logic [DATA_W-1:0] TERM_W  = DATA_W'(TERM_CODE);
  localparam logic [DATA_W-1:0] IDLE_W  = DATA_W'(IDLE_CODE);
  localparam logic [LEN_W-1:0]  DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_SEND = 2'd1,
    ST_TERM = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]  frame_len_q, frame_len_d;
  logic              err_rsvd_q, err_rsvd_d;
  logic              err_ovf_q, err_ovf_d;
  logic [DATA_W-1:0] first_q, first_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_rd_q;
  logic              mem_we;

  logic              wr_ready_c;
  logic              is_rsvd;
  logic              last_rd;
  logic [DATA_W-1:0] tx_data_c;

  assign wr_ready_c = (state_q == ST_FILL) && (frame_len_q < DEPTH_L);
  assign is_rsvd    = (bus.wr_data == IDLE_W) || (bus.wr_data == TERM_W);
  assign last_rd    = (LEN_W'(rd_ptr_q) == (frame_len_q - LEN_W'(1)));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_len_d = frame_len_q;
    err_rsvd_d  = err_rsvd_q;
    err_ovf_d   = err_ovf_q;
    first_d     = first_q;
    mem_we      = 1'b0;

    case (state_q)
      ST_FILL: begin
        // wr_ready is low in FILL only when the frame is full
        if (bus.wr_valid && !wr_ready_c) begin
          err_ovf_d = 1'b1;
        end
        if (bus.wr_valid && wr_ready_c) begin
          if (is_rsvd) begin
            err_rsvd_d = 1'b1;
          end else begin
            mem_we      = 1'b1;
            wr_ptr_d    = wr_ptr_q + PTR_W'(1);
            frame_len_d = frame_len_q + LEN_W'(1);
            if (wr_ptr_q == '0) begin
              first_d = bus.wr_data;
            end
          end
        end
        // frame_len_d already counts a word written alongside commit
        if (bus.commit && (frame_len_d != '0)) begin
          state_d  = ST_SEND;
          rd_ptr_d = '0;
        end
      end

      ST_SEND: begin
        if (bus.tx_ready) begin
          if (last_rd) begin
            state_d = ST_TERM;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end

      ST_TERM: begin
        if (bus.tx_ready) begin
          state_d     = ST_FILL;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          frame_len_d = '0;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_len_q <= '0;
      err_rsvd_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_len_q <= frame_len_d;
      err_rsvd_q  <= err_rsvd_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // Word 0 is kept beside the RAM so a frame committed on the cycle of its only
  // write can be presented immediately without a read-during-write hazard.
  always_ff @(posedge clk) begin
    first_q <= first_d;
  end

  // Reading at the next pointer keeps the following word ready for a stall-free stream.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
    mem_rd_q <= mem[rd_ptr_d];
  end

  always_comb begin
    tx_data_c = IDLE_W;
    case (state_q)
      ST_SEND: tx_data_c = (rd_ptr_q == '0) ? first_q : mem_rd_q;
      ST_TERM: tx_data_c = TERM_W;
      default: tx_data_c = IDLE_W;
    endcase
  end

  assign bus.wr_ready  = wr_ready_c;
  assign bus.tx_valid  = (state_q != ST_FILL);
  assign bus.busy      = (state_q != ST_FILL);
  assign bus.tx_data   = tx_data_c;
  assign bus.frame_len = frame_len_q;
  assign bus.err_rsvd  = err_rsvd_q;
  assign bus.err_ovf   = err_ovf_q;
endmodule

// File: tb/tb_spi_frame_tx_buffer.sv
// Bench for spi_frame_tx_buffer: vector table, directed corner sequences and random
// traffic, all compared against a queue-based frame model kept here.
module tb_spi_frame_tx_buffer;
  localparam int DATA_W = 9;
  localparam int DEPTH  = 256;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  spi_frame_tx_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  spi_frame_tx_buffer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .TERM_CODE(256), .IDLE_CODE(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model: the frame being collected and the words still to be transmitted.
  int frame_q[$];
  int txq[$];
  bit m_sending = 1'b0;
  bit m_rsvd    = 1'b0;
  bit m_ovf     = 1'b0;
  int frames_sent = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      frame_q.delete();
      txq.delete();
      m_sending = 1'b0;
      m_rsvd    = 1'b0;
      m_ovf     = 1'b0;
    end else if (!m_sending) begin
      if (bus.wr_valid) begin
        if (frame_q.size() == DEPTH) m_ovf = 1'b1;
        else if (bus.wr_data == 0 || bus.wr_data == 256) m_rsvd = 1'b1;
        else frame_q.push_back(int'(bus.wr_data));
      end
      if (bus.commit && frame_q.size() > 0) begin
        txq = frame_q;
        txq.push_back(256);
        m_sending = 1'b1;
      end
    end else if (bus.tx_ready) begin
      void'(txq.pop_front());
      if (txq.size() == 0) begin
        frames_sent++;
        $display("frame %0d sent: %0d data words + terminator", frames_sent, frame_q.size());
        m_sending = 1'b0;
        frame_q.delete();
      end
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, " tx_valid"},  int'(bus.tx_valid),  int'(m_sending));
    chk({tag, " tx_data"},   int'(bus.tx_data),   m_sending ? txq[0] : 0);
    chk({tag, " frame_len"}, int'(bus.frame_len), frame_q.size());
    chk({tag, " wr_ready"},  int'(bus.wr_ready),  int'(!m_sending && frame_q.size() < DEPTH));
    chk({tag, " busy"},      int'(bus.busy),      int'(m_sending));
    chk({tag, " err_rsvd"},  int'(bus.err_rsvd),  int'(m_rsvd));
    chk({tag, " err_ovf"},   int'(bus.err_ovf),   int'(m_ovf));
  endtask

  task automatic drive(input bit wv, input int wd, input bit cm, input bit tr);
    bus.wr_valid = wv;
    bus.wr_data  = DATA_W'(wd);
    bus.commit   = cm;
    bus.tx_ready = tr;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    reset = 1'b0;
    step("reset");
    reset = 1'b1;
  endtask

  typedef struct {
    bit wv; int wd; bit cm; bit tr;
    bit e_valid; int e_data; int e_len; bit e_wready; bit e_rsvd;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit wv, input int wd, input bit cm, input bit tr,
                     input bit ev, input int ed, input int el, input bit ew, input bit er);
    vec_t v;
    v.wv = wv; v.wd = wd; v.cm = cm; v.tr = tr;
    v.e_valid = ev; v.e_data = ed; v.e_len = el; v.e_wready = ew; v.e_rsvd = er;
    vecs.push_back(v);
  endtask

  bit r_wv, r_cm, r_tr;
  int r_wd;

  initial begin
    // inputs: wv wd cm tr | expected after the edge: valid data len wr_ready err_rsvd
    add(0,   0, 1, 0,  0,   0, 0, 1, 0);  // commit on empty frame ignored
    add(1,   5, 0, 0,  0,   0, 1, 1, 0);
    add(1,  17, 0, 0,  0,   0, 2, 1, 0);
    add(1, 200, 0, 0,  0,   0, 3, 1, 0);
    add(0,   0, 1, 1,  1,   5, 3, 0, 0);
    add(0,   0, 0, 1,  1,  17, 3, 0, 0);
    add(0,   0, 0, 1,  1, 200, 3, 0, 0);
    add(0,   0, 0, 1,  1, 256, 3, 0, 0);
    add(0,   0, 0, 1,  0,   0, 0, 1, 0);
    add(1,   3, 0, 0,  0,   0, 1, 1, 0);
    add(1,   4, 1, 0,  1,   3, 2, 0, 0);  // write and commit together
    add(0,   0, 0, 1,  1,   4, 2, 0, 0);
    add(1,   9, 1, 0,  1,   4, 2, 0, 0);  // stalled; write/commit ignored while sending
    add(0,   0, 0, 0,  1,   4, 2, 0, 0);
    add(0,   0, 0, 1,  1, 256, 2, 0, 0);
    add(0,   0, 0, 1,  0,   0, 0, 1, 0);
    add(1,   7, 0, 0,  0,   0, 1, 1, 0);
    add(1,   0, 0, 0,  0,   0, 1, 1, 1);
    add(1,   8, 0, 0,  0,   0, 2, 1, 1);
    add(1, 256, 0, 0,  0,   0, 2, 1, 1);
    add(0,   0, 1, 0,  1,   7, 2, 0, 1);
    add(0,   0, 0, 1,  1,   8, 2, 0, 1);
    add(0,   0, 0, 1,  1, 256, 2, 0, 1);
    add(0,   0, 0, 1,  0,   0, 0, 1, 1);

    drive(0, 0, 0, 0);
    do_reset();
    chk("reset tx_valid",  int'(bus.tx_valid),  0);
    chk("reset tx_data",   int'(bus.tx_data),   0);
    chk("reset frame_len", int'(bus.frame_len), 0);
    chk("reset wr_ready",  int'(bus.wr_ready),  1);
    chk("reset busy",      int'(bus.busy),      0);
    chk("reset err_rsvd",  int'(bus.err_rsvd),  0);
    chk("reset err_ovf",   int'(bus.err_ovf),   0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wv, vecs[i].wd, vecs[i].cm, vecs[i].tr);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tx_valid", i),  int'(bus.tx_valid),  int'(vecs[i].e_valid));
      chk($sformatf("vec%0d tx_data", i),   int'(bus.tx_data),   vecs[i].e_data);
      chk($sformatf("vec%0d frame_len", i), int'(bus.frame_len), vecs[i].e_len);
      chk($sformatf("vec%0d wr_ready", i),  int'(bus.wr_ready),  int'(vecs[i].e_wready));
      chk($sformatf("vec%0d err_rsvd", i),  int'(bus.err_rsvd),  int'(vecs[i].e_rsvd));
    end

    // Single word 9 written on the commit cycle of an empty frame
    drive(1, 9, 1, 0);
    step("single");
    chk("single tx_valid", int'(bus.tx_valid), 1);
    chk("single tx_data",  int'(bus.tx_data),  9);
    chk("single len",      int'(bus.frame_len), 1);
    drive(0, 0, 0, 1);
    step("single term");
    chk("single term data", int'(bus.tx_data), 256);
    step("single done");
    chk("single done valid", int'(bus.tx_valid), 0);

    // Full frame of DEPTH words, then overflow attempt
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, (i % 255) + 1, 0, 0);
      step("fill");
    end
    chk("full frame_len", int'(bus.frame_len), 256);
    chk("full wr_ready",  int'(bus.wr_ready),  0);
    chk("full err_ovf",   int'(bus.err_ovf),   0);
    drive(1, 77, 0, 0);
    step("ovf");
    chk("ovf err_ovf",   int'(bus.err_ovf),   1);
    chk("ovf frame_len", int'(bus.frame_len), 256);
    drive(0, 0, 1, 0);
    step("full commit");
    chk("full first", int'(bus.tx_data), 1);
    drive(0, 0, 0, 1);
    for (int i = 1; i <= DEPTH; i++) begin
      step("full stream");
      chk($sformatf("full word%0d", i), int'(bus.tx_data), (i < DEPTH) ? (i % 255) + 1 : 256);
    end
    step("full end");
    chk("full end valid", int'(bus.tx_valid), 0);
    chk("full end len",   int'(bus.frame_len), 0);

    // Reset in the middle of a 4-word frame: no terminator afterwards
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1, k, 0, 0);
      step("abort fill");
    end
    drive(0, 0, 1, 0);
    step("abort commit");
    drive(0, 0, 0, 1);
    step("abort w1");
    step("abort w2");
    chk("abort pre data", int'(bus.tx_data), 3);
    drive(0, 0, 0, 0);
    reset = 1'b0;
    step("abort rst");
    chk("abort tx_valid",  int'(bus.tx_valid),  0);
    chk("abort tx_data",   int'(bus.tx_data),   0);
    chk("abort frame_len", int'(bus.frame_len), 0);
    reset = 1'b1;
    drive(0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      step("abort after");
      chk("abort no term", int'(bus.tx_valid), 0);
    end

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      r_wv = ($urandom_range(0, 3) != 0);
      r_wd = int'($urandom_range(1, 511));
      if ($urandom_range(0, 15) == 0) r_wd = ($urandom_range(0, 1) != 0) ? 0 : 256;
      r_cm = ($urandom_range(0, 24) == 0);
      r_tr = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 1999) != 0);
      drive(r_wv, r_wd, r_cm, r_tr);
      step("rand");
    end
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
